// File: rtl/qaccum_if.sv
// dti_s_if: simple valid/ready stream interface.
//   data   - payload, width W
//   dvalid - producer has a beat on data
//   dready - consumer accepts the beat this cycle
//   eot    - end-of-transaction marker (unused by some links)
interface dti_s_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         dvalid;
  logic         dready;
  logic         eot;

  modport producer (output data, output dvalid, output eot, input dready);
  modport consumer (input data, input dvalid, input eot, output dready);
endinterface

// File: rtl/qaccum.sv
// qaccum: accumulates the elements of each din transaction and emits one
// {count, sum} result per transaction when the eot beat is accepted.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   din  - consumer; data = {eot, element[W_DATA-1:0]}
//   dout - producer; data = {cnt[W_CNT-1:0], sum[W_SUM-1:0]}, eot tied 0
module qaccum #(
  parameter int W_DATA = 16,
  parameter int W_SUM  = 32,
  parameter int W_CNT  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  dti_s_if.consumer  din,
  dti_s_if.producer  dout
);

  localparam int W_OUT = W_CNT + W_SUM;

  if ($bits(din.data) != W_DATA + 1) begin : g_din_chk
    $fatal(1, "qaccum: din.data width does not match W_DATA+1");
  end
  if ($bits(dout.data) != W_OUT) begin : g_dout_chk
    $fatal(1, "qaccum: dout.data width does not match W_CNT+W_SUM");
  end

  logic [W_SUM-1:0]  acc;
  logic [W_CNT-1:0]  cnt;
  logic              out_valid;
  logic [W_OUT-1:0]  out_reg;

  logic              eot;
  logic [W_DATA-1:0] elem;
  logic [W_SUM-1:0]  elem_ext;
  logic [W_SUM-1:0]  acc_next;
  logic [W_CNT-1:0]  cnt_next;
  logic              din_hs;
  logic              dout_hs;
  logic              unused_din_eot;

  assign eot  = din.data[W_DATA];
  assign elem = din.data[W_DATA-1:0];

  // The eot marker travels inside din.data; the side-band eot is ignored.
  assign unused_din_eot = din.eot;

  if (W_SUM == W_DATA) begin : g_ext_none
    assign elem_ext = elem;
  end else if (SIGNED) begin : g_ext_sign
    assign elem_ext = {{(W_SUM-W_DATA){elem[W_DATA-1]}}, elem};
  end else begin : g_ext_zero
    assign elem_ext = {{(W_SUM-W_DATA){1'b0}}, elem};
  end

  assign acc_next = acc + elem_ext;
  assign cnt_next = cnt + W_CNT'(1);

  // Only an eot beat needs the output slot, so only it can be stalled.
  assign din.dready = !eot || !out_valid || dout.dready;
  assign din_hs     = din.dvalid && din.dready;
  assign dout_hs    = out_valid && dout.dready;

  assign dout.dvalid = out_valid;
  assign dout.data   = out_reg;
  assign dout.eot    = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_reg   <= '0;
    end else if (din_hs && !eot) begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (dout_hs) begin
        out_valid <= 1'b0;
      end
    end else if (din_hs && eot) begin
      // A same-cycle dout handshake frees the slot, so the new result
      // overwrites it with no bubble.
      out_reg   <= {cnt_next, acc_next};
      out_valid <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
    end else if (dout_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qaccum.sv
module tb_qaccum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u0: defaults (unsigned, W_DATA=16, W_SUM=32, W_CNT=16)
  dti_s_if #(.W(17)) din0 ();
  dti_s_if #(.W(48)) dout0 ();
  // u1: signed
  dti_s_if #(.W(17)) din1 ();
  dti_s_if #(.W(48)) dout1 ();
  // u2: narrow fields for wrap
  dti_s_if #(.W(9))  din2 ();
  dti_s_if #(.W(10)) dout2 ();

  qaccum u0 (.clk(clk), .rst(rst), .din(din0), .dout(dout0));
  qaccum #(.SIGNED(1'b1)) u1 (.clk(clk), .rst(rst), .din(din1), .dout(dout1));
  qaccum #(.W_DATA(8), .W_SUM(8), .W_CNT(2)) u2 (.clk(clk), .rst(rst), .din(din2), .dout(dout2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic        e;
    logic [15:0] d;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_cnt;
    logic [31:0] e_sum;
    logic        e_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic e, input logic [15:0] d,
                     input logic ordy, input logic e_ov, input logic [15:0] e_cnt,
                     input logic [31:0] e_sum, input logic e_ir);
    vec_t x;
    x.r = r; x.v = v; x.e = e; x.d = d; x.ordy = ordy;
    x.e_ov = e_ov; x.e_cnt = e_cnt; x.e_sum = e_sum; x.e_ir = e_ir;
    vecs.push_back(x);
  endtask

  initial begin
    din0.dvalid = 0; din0.data = '0; din0.eot = 0; dout0.dready = 1;
    din1.dvalid = 0; din1.data = '0; din1.eot = 0; dout1.dready = 1;
    din2.dvalid = 0; din2.data = '0; din2.eot = 0; dout2.dready = 1;

    //   r  v  e  d       ordy ov cnt sum  ir      (outputs seen before the edge)
    add(1, 0, 0, 16'd0,  1,   0, 0, 0,   1);  // reset state
    // 3,5,7(eot)
    add(0, 1, 0, 16'd3,  1,   0, 0, 0,   1);
    add(0, 1, 0, 16'd5,  1,   0, 0, 0,   1);
    add(0, 1, 1, 16'd7,  1,   0, 0, 0,   1);
    add(0, 0, 0, 16'd0,  1,   1, 3, 15,  1);
    add(0, 0, 0, 16'd0,  1,   0, 3, 15,  1);
    // dready low: 1(eot), then 2, 4(eot) stalled
    add(0, 1, 1, 16'd1,  0,   0, 3, 15,  1);
    add(0, 1, 0, 16'd2,  0,   1, 1, 1,   1);
    add(0, 1, 1, 16'd4,  0,   1, 1, 1,   0);
    add(0, 1, 1, 16'd4,  0,   1, 1, 1,   0);
    add(0, 1, 1, 16'd4,  1,   1, 1, 1,   1);
    add(0, 0, 0, 16'd0,  1,   1, 2, 6,   1);
    add(0, 0, 0, 16'd0,  1,   0, 2, 6,   1);
    // back-to-back single-beat transactions
    add(0, 1, 1, 16'd10, 1,   0, 2, 6,   1);
    add(0, 1, 1, 16'd20, 1,   1, 1, 10,  1);
    add(0, 1, 1, 16'd30, 1,   1, 1, 20,  1);
    add(0, 0, 0, 16'd0,  1,   1, 1, 30,  1);
    add(0, 0, 0, 16'd0,  1,   0, 1, 30,  1);
    // dvalid gap mid-transaction: 9, (gap), 1(eot)
    add(0, 1, 0, 16'd9,  1,   0, 1, 30,  1);
    add(0, 0, 1, 16'd100,1,   0, 1, 30,  1);
    add(0, 1, 1, 16'd1,  1,   0, 1, 30,  1);
    add(0, 0, 0, 16'd0,  1,   1, 2, 10,  1);
    add(0, 0, 0, 16'd0,  1,   0, 2, 10,  1);
    // 9,9, reset, 4(eot)
    add(0, 1, 0, 16'd9,  1,   0, 2, 10,  1);
    add(0, 1, 0, 16'd9,  1,   0, 2, 10,  1);
    add(1, 0, 0, 16'd0,  1,   0, 2, 10,  1);
    add(0, 0, 0, 16'd0,  1,   0, 0, 0,   1);
    add(0, 1, 1, 16'd4,  1,   0, 0, 0,   1);
    add(0, 0, 0, 16'd0,  1,   1, 1, 4,   1);
    add(0, 0, 0, 16'd0,  1,   0, 1, 4,   1);
    // reset beats a same-cycle eot handshake
    add(1, 1, 1, 16'd5,  1,   0, 1, 4,   1);
    add(0, 0, 0, 16'd0,  1,   0, 0, 0,   1);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst          = vecs[i].r;
      din0.dvalid  = vecs[i].v;
      din0.data    = {vecs[i].e, vecs[i].d};
      dout0.dready = vecs[i].ordy;
      #1;
      check($sformatf("row%0d dvalid", i), 64'(dout0.dvalid), 64'(vecs[i].e_ov));
      check($sformatf("row%0d data", i), 64'(dout0.data), 64'({vecs[i].e_cnt, vecs[i].e_sum}));
      check($sformatf("row%0d din_ready", i), 64'(din0.dready), 64'(vecs[i].e_ir));
    end

    // Signed vs unsigned extension, plus wrap of narrow fields.
    @(negedge clk);
    rst = 0;
    din0.dvalid = 0; dout0.dready = 1;
    #1;
    check("u1 reset dvalid", 64'(dout1.dvalid), 64'd0);
    check("u2 reset dvalid", 64'(dout2.dvalid), 64'd0);
    din0.dvalid = 1; din0.data = {1'b0, 16'hFFFF};
    din1.dvalid = 1; din1.data = {1'b0, 16'hFFFF};
    din2.dvalid = 1; din2.data = {1'b0, 8'd200};
    @(negedge clk);
    din0.data = {1'b1, 16'h0002};
    din1.data = {1'b1, 16'h0002};
    din2.data = {1'b0, 8'd100};
    @(negedge clk);
    din0.dvalid = 0; din1.dvalid = 0;
    din2.data = {1'b0, 8'd1};
    #1;
    check("u0 unsigned dvalid", 64'(dout0.dvalid), 64'd1);
    check("u0 unsigned result", 64'(dout0.data), {16'd0, 16'd2, 32'h0001_0001});
    check("u1 signed dvalid", 64'(dout1.dvalid), 64'd1);
    check("u1 signed result", 64'(dout1.data), {16'd0, 16'd2, 32'h0000_0001});
    check("u2 mid dvalid", 64'(dout2.dvalid), 64'd0);
    @(negedge clk);
    din2.data = {1'b1, 8'd1};
    @(negedge clk);
    din2.dvalid = 0;
    #1;
    check("u2 wrap dvalid", 64'(dout2.dvalid), 64'd1);
    check("u2 wrap result", 64'(dout2.data), {54'd0, 2'd0, 8'd46});
    check("u1 drained", 64'(dout1.dvalid), 64'd0);
    @(negedge clk);
    #1;
    check("u2 drained", 64'(dout2.dvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qaccum.md
QACCUM -- requirements
Module: qaccum

Interface
REQ-001 Parameter W_DATA, default 16: width of the element data field of din.
REQ-002 Parameter W_SUM, default 32: width of the sum accumulator and result sum field; SHALL be >= W_DATA.
REQ-003 Parameter W_CNT, default 16: width of the element counter and result count field.
REQ-004 Parameter SIGNED, default 0: 1 sign-extends din data into the accumulator; 0 zero-extends it.
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 din  dti_s_if.consumer  W_DATA+1  queue input; data[W_DATA] = eot, data[W_DATA-1:0] = element; dvalid/dready handshake.
REQ-008 dout  dti_s_if.producer  W_CNT+W_SUM  result; data = {cnt[W_CNT-1:0], sum[W_SUM-1:0]}, cnt in MSBs; dout.eot tied 0.

Function
REQ-009 Handshake definitions: din handshake = din.dvalid & din.dready; dout handshake = dout.dvalid & dout.dready.
REQ-010 Internal state: acc (W_SUM), cnt (W_CNT), out_valid (1), out_reg (W_CNT+W_SUM).
REQ-011 dout.dvalid SHALL equal out_valid; dout.data SHALL equal out_reg.
REQ-012 din.dready SHALL be (!din.data[W_DATA]) | (!out_valid) | dout.dready; non-eot beats are never stalled.
REQ-013 On a non-eot din handshake: acc <= acc + ext(element); cnt <= cnt + 1.
REQ-014 On an eot din handshake: out_reg <= {cnt+1, acc+ext(element)}; out_valid <= 1; acc <= 0; cnt <= 0.
REQ-015 ext() SHALL sign-extend to W_SUM when SIGNED=1 and zero-extend otherwise.
REQ-016 All additions wrap modulo 2^W_SUM (sum) or 2^W_CNT (count); no saturation and no overflow flag.
REQ-017 A result SHALL be visible on dout exactly one cycle after its eot handshake.
REQ-018 On a dout handshake without a same-cycle eot din handshake: out_valid <= 0.
REQ-019 A dout handshake and an eot din handshake in the same cycle SHALL load the new result and keep out_valid = 1, with no bubble and no lost result.
REQ-020 out_reg SHALL hold stable while out_valid = 1 and dout.dready = 0.
REQ-021 A single-element transaction (eot on the first beat) SHALL produce cnt = 1 and sum = ext(element).
REQ-022 din.dvalid deasserting between beats SHALL pause accumulation without altering acc or cnt.
REQ-023 Elaboration check: $size(din.data) == W_DATA+1 and $size(dout.data) == W_CNT+W_SUM, else $fatal.

Reset
REQ-024 While rst = 1: acc = 0, cnt = 0, out_valid = 0, out_reg = 0; dout.dvalid SHALL read 0 in the cycle after rst is sampled high.
REQ-025 rst asserted mid-transaction SHALL discard the partial sum and count; the first beat after reset starts a new transaction.
REQ-026 rst SHALL take priority over any same-cycle handshake.

Verification
REQ-027 W_DATA=16, SIGNED=0; din 3,5,7(eot), dout.dready=1 -> one result {cnt=3, sum=15}, valid the cycle after the eot beat.
REQ-028 SIGNED=1; din 0xFFFF, 0x0002(eot) -> {cnt=2, sum=1}; same stimulus with SIGNED=0 -> {cnt=2, sum=0x10001}.
REQ-029 dout.dready=0; send 1(eot) then 2,4(eot) -> 2 accepted, 4(eot) stalled with din.dready=0, dout holds {1,1}; raise dready -> {1,1} then {2,6} back-to-back.
REQ-030 Continuous single-beat eot stream 10,20,30 with dout.dready=1 -> results {1,10},{1,20},{1,30} on consecutive cycles; din.dready stays 1.
REQ-031 Send 9,9, then assert rst for 1 cycle, then send 4(eot) -> dout.dvalid=0 during reset; single result {1,4}.
REQ-032 W_SUM=8, W_CNT=2; din 200,100,1,1(eot) -> {cnt=0, sum=46}, confirming wrap of both fields.
